// File: rtl/sha256_pkg.sv
// Shared encodings and constants for the SHA-256 message feeder and its users.
package sha256_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Work still owed to the current message once the in-flight block finishes.
  typedef enum logic [1:0] {
    PH_DATA,
    PH_NEED_PAD,
    PH_NEED_LEN,
    PH_FINAL
  } phase_t;

endpackage

// File: rtl/sha256_msg_feeder.sv
// Packs a word stream into padded SHA-256 blocks, drives the core with chaining
// inputs, and hands the final digest out over a valid/ready handshake.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 27
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [31:0]         msg_data,
  input  logic                msg_last,
  output logic                core_init,
  output logic [BLOCK_W-1:0]  core_block,
  output logic                core_first_block,
  output logic [DIGEST_W-1:0] core_prev_digest,
  input  logic                core_digest_valid,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [DIGEST_W-1:0] dout_digest
);

  state_t                r_state, w_state_nxt;
  phase_t                r_phase, w_phase_nxt;
  logic [3:0]            r_wptr;
  logic [LEN_W-1:0]      r_len;
  logic [31:0]           r_blk [16];
  logic                  r_first;
  logic [DIGEST_W-1:0]   r_prev_digest;
  logic [DIGEST_W-1:0]   r_dout_digest;
  logic                  r_dv_prev;

  logic                  w_accept;
  logic                  w_edge;
  logic                  w_out_done;
  logic [LEN_W+4:0]      w_bits;
  logic [31:0]           w_bitlen;

  assign w_bits     = {r_len, 5'b0};
  assign w_bitlen   = 32'(w_bits);
  assign w_accept   = (r_state == ST_FILL) && msg_valid;
  // Only a fresh 0->1 transition seen while waiting counts as completion.
  assign w_edge     = (r_state == ST_WAIT) && core_digest_valid && !r_dv_prev;
  assign w_out_done = (r_state == ST_OUT) && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_phase <= PH_DATA;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    unique case (r_state)
      ST_FILL: begin
        if (msg_valid) begin
          if (msg_last) begin
            if (r_wptr == 4'd15) begin
              w_state_nxt = ST_ISSUE;
              w_phase_nxt = PH_NEED_PAD;
            end else begin
              w_state_nxt = ST_PAD;
            end
          end else if (r_wptr == 4'd15) begin
            w_state_nxt = ST_ISSUE;
            w_phase_nxt = PH_DATA;
          end
        end
      end
      ST_PAD: begin
        w_state_nxt = ST_ISSUE;
        w_phase_nxt = (r_wptr <= 4'd13) ? PH_FINAL : PH_NEED_LEN;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_edge) begin
          unique case (r_phase)
            PH_DATA:     w_state_nxt = ST_FILL;
            PH_NEED_PAD: w_state_nxt = ST_PAD;
            PH_NEED_LEN: begin
              w_state_nxt = ST_ISSUE;
              w_phase_nxt = PH_FINAL;
            end
            PH_FINAL:    w_state_nxt = ST_OUT;
            default:     w_state_nxt = ST_FILL;
          endcase
        end
      end
      ST_OUT: begin
        if (dout_ready) begin
          w_state_nxt = ST_FILL;
          w_phase_nxt = PH_DATA;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr        <= '0;
      r_len         <= '0;
      r_blk         <= '{default: '0};
      r_first       <= 1'b1;
      r_prev_digest <= '0;
      r_dout_digest <= '0;
      r_dv_prev     <= 1'b0;
    end else begin
      r_dv_prev <= core_digest_valid;

      if (w_accept) begin
        r_blk[r_wptr] <= msg_data;
        r_wptr        <= r_wptr + 4'd1;
        r_len         <= r_len + 1'b1;
      end

      // Slots below the marker keep message data; the length lands in slot 15
      // only when slots 14/15 are still free in this block.
      if (r_state == ST_PAD) begin
        for (int unsigned i = 0; i < 16; i++) begin
          if (i[3:0] == r_wptr)
            r_blk[i[3:0]] <= SHA256_PAD_WORD;
          else if (i[3:0] > r_wptr)
            r_blk[i[3:0]] <= '0;
        end
        if (r_wptr <= 4'd13)
          r_blk[15] <= w_bitlen;
      end

      if (r_state == ST_ISSUE)
        r_first <= 1'b0;

      if (w_edge) begin
        r_prev_digest <= core_digest;
        unique case (r_phase)
          PH_DATA, PH_NEED_PAD: r_wptr <= '0;
          PH_NEED_LEN: begin
            for (int unsigned i = 0; i < 15; i++)
              r_blk[i[3:0]] <= '0;
            r_blk[15] <= w_bitlen;
          end
          PH_FINAL: r_dout_digest <= core_digest;
          default: ;
        endcase
      end

      if (w_out_done) begin
        r_len   <= '0;
        r_wptr  <= '0;
        r_first <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign core_block[BLOCK_W-1-32*g -: 32] = r_blk[g];
  end

  assign msg_ready        = (r_state == ST_FILL) && !reset;
  assign core_init        = (r_state == ST_ISSUE) && !reset;
  assign dout_valid       = (r_state == ST_OUT) && !reset;
  assign core_first_block = r_first;
  assign core_prev_digest = r_prev_digest;
  assign dout_digest      = r_dout_digest;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: acts as the SHA-256 core and compares issued
// blocks and final digests against a padded-message reference model.
module tb_sha256_msg_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_data;
  logic         msg_last;
  logic         core_init;
  logic [511:0] core_block;
  logic         core_first_block;
  logic [255:0] core_prev_digest;
  logic         core_digest_valid;
  logic [255:0] core_digest;
  logic         dout_valid;
  logic         dout_ready;
  logic [255:0] dout_digest;

  sha256_msg_feeder #(.LEN_W(27)) dut (
    .clk               (clk),
    .reset             (reset),
    .msg_valid         (msg_valid),
    .msg_ready         (msg_ready),
    .msg_data          (msg_data),
    .msg_last          (msg_last),
    .core_init         (core_init),
    .core_block        (core_block),
    .core_first_block  (core_first_block),
    .core_prev_digest  (core_prev_digest),
    .core_digest_valid (core_digest_valid),
    .core_digest       (core_digest),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .dout_digest       (dout_digest)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  msg_q [$];
  logic [511:0] exp_blk_q [$];
  bit           exp_first_q [$];
  logic [255:0] exp_prev_q [$];
  logic [255:0] exp_final;

  int           issued = 0;
  int           core_lat = 0;
  int           core_lat_fixed = 0;
  bit           core_busy = 0;
  bit           core_stale = 0;
  logic [511:0] core_cap;
  logic [255:0] core_res;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Standard SHA-256 padding of a word-aligned message, then chain the blocks.
  task automatic build_exp(input int n, output int nb);
    logic [31:0]  pw [$];
    logic [511:0] blk;
    logic [255:0] h;
    pw = msg_q;
    pw.push_back(32'h80000000);
    while (pw.size() % 16 != 14) pw.push_back(32'h0);
    pw.push_back(32'h0);
    pw.push_back(32'(n * 32));
    nb = pw.size() / 16;
    exp_blk_q.delete(); exp_first_q.delete(); exp_prev_q.delete();
    h = IV;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = pw[16*b + i];
      exp_blk_q.push_back(blk);
      exp_first_q.push_back(b == 0);
      exp_prev_q.push_back(h);
      h = sha_compress(h, blk);
    end
    exp_final = h;
  endtask

  // Core model: level-style done, dropped when a new block starts.
  initial begin
    core_digest_valid = 1'b0;
    core_digest = '0;
    forever begin
      @(negedge clk);
      if (core_init) begin
        issued++;
        core_stale = 0;
        if (exp_blk_q.size() == 0) begin
          check("unexpected_block", exp_blk_q.size(), 1);
        end else begin
          check("block", core_block, exp_blk_q.pop_front());
          check("first_block", core_first_block, exp_first_q[0]);
          if (!exp_first_q[0]) check("prev_digest", core_prev_digest, exp_prev_q[0]);
          void'(exp_first_q.pop_front());
          void'(exp_prev_q.pop_front());
        end
        core_cap = core_block;
        core_res = sha_compress(core_first_block ? IV : core_prev_digest, core_block);
        core_digest_valid = 1'b0;
        core_lat = (core_lat_fixed != 0) ? core_lat_fixed : int'($urandom_range(1, 6));
        core_busy = 1;
      end else if (core_busy) begin
        core_lat--;
        if (core_lat == 0) begin
          if (!core_stale) check("block_hold", core_block, core_cap);
          core_digest = core_res;
          core_digest_valid = 1'b1;
          core_busy = 0;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last);
    bit done = 0;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = last;
    for (int c = 0; c < 300 && !done; c++) begin
      if (msg_ready) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if (!done) check("accept_timeout", done, 1);
  endtask

  task automatic run_msg(input int n, input bit abcd, input bit gappy, input int hold);
    int nb, base;
    bit seen = 0;
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(abcd ? 32'h61626364 : $urandom);
    build_exp(n, nb);
    base = issued;
    for (int i = 0; i < n; i++) begin
      if (gappy && i > 0) @(negedge clk);
      send_word(msg_q[i], i == n - 1);
    end
    if (n % 16 == 0) begin
      check("init_after_full", core_init, 1);
    end else begin
      check("pad_no_init", core_init, 0);
      check("pad_not_ready", msg_ready, 0);
      @(negedge clk);
      check("init_after_pad", core_init, 1);
    end
    for (int c = 0; c < 400; c++) begin
      if (dout_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("dout_seen", seen, 1);
    if (seen) begin
      for (int k = 0; k < hold; k++) begin
        check("dout_hold_valid", dout_valid, 1);
        check("dout_hold_digest", dout_digest, exp_final);
        @(negedge clk);
      end
      check("digest", dout_digest, exp_final);
      check("out_not_ready", msg_ready, 0);
      dout_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dout_ready = 1'b0;
      check("dout_cleared", dout_valid, 0);
      check("ready_after_out", msg_ready, 1);
    end
    check("num_blocks", issued - base, nb);
    check("blocks_left", exp_blk_q.size(), 0);
  endtask

  task automatic reset_mid_wait();
    int nb, base;
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back($urandom);
    build_exp(20, nb);
    core_lat_fixed = 10;
    for (int i = 0; i < 16; i++) send_word(msg_q[i], 1'b0);
    check("rst_issue", core_init, 1);
    @(negedge clk);
    base = issued;
    core_stale = 1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", msg_ready, 0);
    check("rst_init", core_init, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_first", core_first_block, 1);
    check("rst_block", core_block, 0);
    check("rst_prev", core_prev_digest, 0);
    reset = 1'b0;
    exp_blk_q.delete(); exp_first_q.delete(); exp_prev_q.delete();
    core_lat_fixed = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("stale_no_dout", dout_valid, 0);
    end
    check("stale_ready", msg_ready, 1);
    check("stale_no_issue", issued - base, 0);
    run_msg(1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens [4] = '{15, 17, 30, 47};
    reset      = 1'b1;
    msg_valid  = 1'b1;
    msg_data   = 32'hdeadbeef;
    msg_last   = 1'b1;
    dout_ready = 1'b0;
    @(negedge clk);
    check("reset_ready", msg_ready, 0);
    check("reset_init", core_init, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_first", core_first_block, 1);
    check("reset_block", core_block, 0);
    check("reset_prev", core_prev_digest, 0);
    check("reset_digest", dout_digest, 0);
    @(negedge clk);
    reset     = 1'b0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    @(negedge clk);
    check("post_reset_ready", msg_ready, 1);

    run_msg(1, 1'b1, 1'b0, 0);
    run_msg(13, 1'b0, 1'b0, 0);
    run_msg(14, 1'b0, 1'b0, 1);
    run_msg(16, 1'b0, 1'b0, 0);
    run_msg(32, 1'b0, 1'b1, 5);
    reset_mid_wait();
    foreach (lens[i]) run_msg(lens[i], 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
